// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / DON'T WALK controller slaved to the vehicle light code.
// Grants WALK only on entry into RED, then runs a flashing clearance countdown.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 6,
    parameter int FLASH_HALF   = 2
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic [0:2] light_i,
    input  logic       button_i,
    output logic       walk_o,
    output logic       dont_walk_o,
    output logic [3:0] countdown_o,
    output logic       req_pending_o,
    output logic       fault_o
);

    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WALK,
        S_CLEAR,
        S_FAULT
    } state_t;

    state_t     state_q, state_d;
    logic [0:2] light_q;
    logic       button_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] sub_q, sub_d;
    logic       flash_q, flash_d;
    logic       req_q, req_d;

    logic legal, is_red, red_entry, btn_edge;

    assign legal     = (light_i == RED) || (light_i == GREEN) || (light_i == YELLOW);
    assign is_red    = (light_i == RED);
    assign red_entry = is_red && (light_q != RED);
    assign btn_edge  = button_i && !button_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        flash_d = flash_q;
        req_d   = req_q;
        if (!legal) begin
            state_d = S_FAULT;
            req_d   = 1'b0;
            cnt_d   = 4'd0;
            flash_d = 1'b1;
            sub_d   = 4'd0;
        end else begin
            case (state_q)
                S_FAULT: state_d = S_IDLE;
                S_IDLE: begin
                    if (btn_edge) begin
                        state_d = S_WAIT;
                        req_d   = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (red_entry) begin
                        state_d = S_WALK;
                        cnt_d   = 4'(WALK_CYCLES - 1);
                        req_d   = 1'b0;
                    end
                end
                S_WALK, S_CLEAR: begin
                    // A press in the same cycle as an abort or expiry is kept.
                    req_d = req_q | btn_edge;
                    if (!is_red) begin
                        state_d = req_d ? S_WAIT : S_IDLE;
                        cnt_d   = 4'd0;
                        flash_d = 1'b1;
                        sub_d   = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        flash_d = 1'b1;
                        sub_d   = 4'd0;
                        if (state_q == S_WALK) begin
                            state_d = S_CLEAR;
                            cnt_d   = 4'(CLEAR_CYCLES - 1);
                        end else begin
                            state_d = req_d ? S_WAIT : S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (state_q == S_CLEAR) begin
                            if (sub_q == 4'(FLASH_HALF - 1)) begin
                                sub_d   = 4'd0;
                                flash_d = !flash_q;
                            end else begin
                                sub_d = sub_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from next-state values so they register alongside the state.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q       <= S_IDLE;
            light_q       <= RED;
            button_q      <= 1'b0;
            cnt_q         <= 4'd0;
            sub_q         <= 4'd0;
            flash_q       <= 1'b1;
            req_q         <= 1'b0;
            walk_o        <= 1'b0;
            dont_walk_o   <= 1'b1;
            countdown_o   <= 4'd0;
            req_pending_o <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            state_q       <= state_d;
            light_q       <= light_i;
            button_q      <= button_i;
            cnt_q         <= cnt_d;
            sub_q         <= sub_d;
            flash_q       <= flash_d;
            req_q         <= req_d;
            walk_o        <= (state_d == S_WALK);
            dont_walk_o   <= (state_d == S_CLEAR) ? flash_d : (state_d != S_WALK);
            countdown_o   <= (state_d == S_CLEAR) ? cnt_d : 4'd0;
            req_pending_o <= req_d;
            fault_o       <= (state_d == S_FAULT);
        end
    end

endmodule
